// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO buffer and its read-side pop controller.
package lifo_pkg;

  localparam int unsigned LIFO_DATA_W = 8;
  localparam int unsigned LIFO_DEPTH  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_HOLD,
    ST_DONE
  } pop_state_e;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_pop_ctrl.sv
// Read-side controller for the LIFO buffer: pops a burst of words one at a
// time and presents each on a valid/ready output register.
module lifo_pop_ctrl
  import lifo_pkg::*;
#(
  parameter  int unsigned DATA_W    = LIFO_DATA_W,
  parameter  int unsigned LIFO_SIZE = LIFO_DEPTH,
  localparam int unsigned CNT_W     = cnt_w(LIFO_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              lifo_empty,
  input  logic [DATA_W-1:0] lifo_data,
  output logic              lifo_read,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              underflow,
  output logic [CNT_W-1:0]  pop_cnt
);

  pop_state_e       state;
  pop_state_e       state_next;
  logic [CNT_W-1:0] remaining;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // lifo_read is a pure decode of ISSUE so it can never repeat on back-to-back cycles.
  always_comb begin
    state_next = state;
    lifo_read  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (burst_len == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (lifo_empty) begin
          state_next = ST_DONE;
        end else begin
          lifo_read  = 1'b1;
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: state_next = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          state_next = (remaining == CNT_W'(1)) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
      pop_cnt   <= '0;
      underflow <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= burst_len;
            pop_cnt   <= '0;
            underflow <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (lifo_empty) begin
            underflow <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          out_data  <= lifo_data;
          out_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pop_cnt   <= pop_cnt + CNT_W'(1);
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  a_no_back_to_back_read: assert property (
    @(posedge clk) disable iff (!reset) lifo_read |=> !lifo_read
  );

  a_remaining_nonzero: assert property (
    @(posedge clk) disable iff (!reset)
      (state == ST_ISSUE || state == ST_HOLD) |-> (remaining != '0)
  );

endmodule

// File: tb/tb_lifo_pop_ctrl.sv
// Self-checking bench for lifo_pop_ctrl with a queue-based LIFO and a
// burst-level reference model.
module tb_lifo_pop_ctrl;
  import lifo_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = cnt_w(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] burst_len;
  logic          lifo_empty;
  logic [DW-1:0] lifo_data;
  logic          lifo_read;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          underflow;
  logic [CW-1:0] pop_cnt;

  lifo_pop_ctrl #(.DATA_W(DW), .LIFO_SIZE(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .burst_len  (burst_len),
    .lifo_empty (lifo_empty),
    .lifo_data  (lifo_data),
    .lifo_read  (lifo_read),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .underflow  (underflow),
    .pop_cnt    (pop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned n_push;
    int unsigned len;
    int unsigned pct;
    bit          restart;
    int unsigned exp_words;
    bit          exp_uf;
  } vec_t;

  vec_t          vec [8];
  logic [DW-1:0] pat [8] = '{8'hFF, 8'h00, 8'hF0, 8'h0F, 8'hA5, 8'h5A, 8'h3C, 8'hC3};

  logic [DW-1:0] stk [$];
  logic [DW-1:0] got [$];
  int            n_reads, n_dones, n_busy, mon_err, first_read, first_valid, done_cyc;
  bit            timed_out;
  int            checks, failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_stack();
    stk.delete();
    lifo_empty = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    stk.push_back(w);
    lifo_empty = 1'b0;
  endtask

  // One clock from negedge to negedge; the LIFO pops just after the edge
  // on which lifo_read was high.
  task automatic tick();
    bit rd;
    rd = lifo_read;
    @(posedge clk);
    #1;
    if (rd) begin
      if (stk.size() == 0) mon_err++;
      else lifo_data = stk.pop_back();
      lifo_empty = (stk.size() == 0);
    end
    @(negedge clk);
  endtask

  task automatic run_burst(input int unsigned len, input int unsigned ready_pct,
                           input int unsigned stall, input bit restart);
    int            cyc;
    int unsigned   post, stall_left;
    bit            prev_read, prev_stall, saw_done, rdy;
    logic [DW-1:0] held;
    got.delete();
    n_reads = 0; n_dones = 0; n_busy = 0; mon_err = 0;
    first_read = -1; first_valid = -1; done_cyc = -1; timed_out = 0;
    stall_left = stall; prev_read = 0; prev_stall = 0; saw_done = 0; post = 0;
    held = '0;
    start = 1'b1; burst_len = CW'(len); out_ready = 1'b0;
    cyc = 0;
    tick();
    start = 1'b0;
    forever begin
      if (lifo_read) begin
        n_reads++;
        if (first_read < 0) first_read = cyc;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (lifo_read && (prev_read || out_valid)) mon_err++;
      if (prev_stall && (!out_valid || out_data !== held)) mon_err++;
      if (busy) n_busy++;
      if (done) begin
        n_dones++;
        if (!saw_done) done_cyc = cyc;
        saw_done = 1;
      end
      if (saw_done) begin
        if (post == 2) break;
        post++;
      end
      if (cyc == 300) begin
        timed_out = 1;
        break;
      end
      if (out_valid && stall_left > 0) begin
        rdy = 0;
        stall_left--;
      end else begin
        rdy = ($urandom_range(99, 0) < ready_pct);
      end
      out_ready = rdy;
      start = restart && (cyc == 3);
      if (start) burst_len = CW'($urandom_range(DEPTH, 1));
      if (out_valid && rdy) got.push_back(out_data);
      prev_stall = out_valid && !rdy;
      held       = out_data;
      prev_read  = lifo_read;
      tick();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  // Expected burst outcome: the top min(len, depth) words in LIFO order,
  // underflow exactly when more words were asked for than were stacked.
  task automatic expect_burst(input string tag, input int unsigned len,
                              input logic [DW-1:0] snap[$], input bit timing);
    int unsigned n;
    bit          uf;
    n  = (len < snap.size()) ? len : snap.size();
    uf = (len > snap.size());
    check($sformatf("%s.timeout", tag), 64'(timed_out), 0);
    check($sformatf("%s.words", tag), 64'(got.size()), 64'(n));
    for (int unsigned k = 0; k < n && k < got.size(); k++)
      check($sformatf("%s.word%0d", tag, k), 64'(got[k]), 64'(snap[snap.size() - 1 - k]));
    check($sformatf("%s.reads", tag), 64'(n_reads), 64'(n));
    check($sformatf("%s.dones", tag), 64'(n_dones), 1);
    check($sformatf("%s.monitor", tag), 64'(mon_err), 0);
    check($sformatf("%s.busy_end", tag), 64'(busy), 0);
    check($sformatf("%s.stack_left", tag), 64'(stk.size()), 64'(snap.size() - n));
    if (len != 0) begin
      check($sformatf("%s.pop_cnt", tag), 64'(pop_cnt), 64'(n));
      check($sformatf("%s.underflow", tag), 64'(underflow), 64'(uf));
    end
    if (timing)
      check($sformatf("%s.busy_cycles", tag), 64'(n_busy), 64'(3 * n + 1 + 32'(uf)));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] snap [$];
    int unsigned   len, pct, stall;
    bit            restart, seen, hold2;

    checks = 0; failures = 0;
    reset = 1'b0; start = 1'b0; burst_len = '0; out_ready = 1'b0;
    lifo_empty = 1'b1; lifo_data = '0;

    vec[0] = '{4, 4, 100, 1'b0, 4, 1'b0};
    vec[1] = '{4, 6, 100, 1'b0, 4, 1'b1};
    vec[2] = '{4, 3, 100, 1'b1, 3, 1'b0};
    vec[3] = '{0, 1, 100, 1'b0, 0, 1'b1};
    vec[4] = '{8, 8,  60, 1'b0, 8, 1'b0};
    vec[5] = '{2, 1,  40, 1'b1, 1, 1'b0};
    vec[6] = '{5, 8, 100, 1'b0, 5, 1'b1};
    vec[7] = '{8, 9, 100, 1'b0, 8, 1'b1};

    #12;
    check("rst.out_valid", 64'(out_valid), 0);
    check("rst.busy", 64'(busy), 0);
    check("rst.done", 64'(done), 0);
    check("rst.underflow", 64'(underflow), 0);
    check("rst.pop_cnt", 64'(pop_cnt), 0);
    check("rst.out_data", 64'(out_data), 0);
    check("rst.lifo_read", 64'(lifo_read), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      clear_stack();
      for (int unsigned j = 0; j < vec[i].n_push; j++) push(pat[j]);
      snap = stk;
      run_burst(vec[i].len, vec[i].pct, 0, vec[i].restart);
      check($sformatf("vec%0d.tbl_words", i), 64'(got.size()), 64'(vec[i].exp_words));
      check($sformatf("vec%0d.tbl_uf", i), 64'(underflow), 64'(vec[i].exp_uf));
      check($sformatf("vec%0d.tbl_pop_cnt", i), 64'(pop_cnt), 64'(vec[i].exp_words));
      expect_burst($sformatf("vec%0d", i), vec[i].len, snap, vec[i].pct == 100);
      if (i == 0) begin
        check("lat.first_read", 64'(first_read), 0);
        check("lat.first_valid", 64'(first_valid), 2);
      end
    end

    // Zero-length burst: straight to DONE, no LIFO traffic.
    clear_stack();
    push(8'h11); push(8'h22);
    snap = stk;
    run_burst(0, 100, 0, 0);
    check("len0.reads", 64'(n_reads), 0);
    check("len0.done_cyc", 64'(done_cyc), 0);
    check("len0.busy_cycles", 64'(n_busy), 1);
    expect_burst("len0", 0, snap, 1);

    // Five-cycle stall on the first word.
    clear_stack();
    for (int unsigned j = 0; j < 4; j++) push(pat[j]);
    snap = stk;
    run_burst(2, 100, 5, 0);
    check("stall.busy_cycles", 64'(n_busy), 12);
    expect_burst("stall", 2, snap, 0);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(3, 0) == 0) clear_stack();
      for (int unsigned j = $urandom_range(4, 0); j > 0 && stk.size() < DEPTH; j--)
        push(DW'($urandom));
      len     = $urandom_range(DEPTH + 2, 0);
      case ($urandom_range(2, 0))
        0:       pct = 40;
        1:       pct = 70;
        default: pct = 100;
      endcase
      stall   = $urandom_range(3, 0);
      restart = (len >= 1) && (stk.size() >= 1) && ($urandom_range(2, 0) == 0);
      snap = stk;
      run_burst(len, pct, stall, restart);
      expect_burst($sformatf("rnd%0d", r), len, snap, (pct == 100) && (stall == 0));
    end

    // Asynchronous reset while the second word of a burst sits in HOLD.
    clear_stack();
    for (int unsigned j = 0; j < 4; j++) push(pat[j]);
    start = 1'b1; burst_len = CW'(3); out_ready = 1'b0;
    tick();
    start = 1'b0;
    seen = 0; hold2 = 0;
    for (int c = 0; c < 40 && !hold2; c++) begin
      if (out_valid) begin
        if (!seen) begin
          check("rstmid.word0", 64'(out_data), 64'h0F);
          out_ready = 1'b1;
          seen = 1;
        end else begin
          hold2 = 1;
        end
      end else begin
        out_ready = 1'b0;
      end
      if (!hold2) tick();
    end
    out_ready = 1'b0;
    check("rstmid.reached_hold", 64'(hold2), 1);
    check("rstmid.word1", 64'(out_data), 64'hF0);
    #2;
    reset = 1'b0;
    #1;
    check("rstmid.out_valid", 64'(out_valid), 0);
    check("rstmid.busy", 64'(busy), 0);
    check("rstmid.lifo_read", 64'(lifo_read), 0);
    check("rstmid.pop_cnt", 64'(pop_cnt), 0);
    @(negedge clk);
    check("rstmid.stack_left", 64'(stk.size()), 2);
    reset = 1'b1;
    @(negedge clk);
    snap = stk;
    run_burst(1, 100, 0, 0);
    check("rstmid.next_word", 64'(got.size() > 0 ? got[0] : 8'hXX), 64'h00);
    expect_burst("rstmid.after", 1, snap, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
